// File: rtl/pll_lock_supervisor_pkg.sv
// rtl/pll_lock_supervisor_pkg.sv - shared types and helpers for the PLL lock supervisor
//
// Purpose: FSM state encoding and counter-sizing helpers used by
//          pll_lock_supervisor.
// Ports:   none (package).

package pll_lock_supervisor_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit above what the largest terminal count needs, so a
  // counter compared against (N-1) can never wrap before it matches.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - multi-flop synchronizer for a single asynchronous status bit
//
// Purpose: brings an asynchronous level (PLL LOCK or similar) into the clk
//          domain through SYNC_STAGES flops.
// Ports:
//   clk      in   sampling clock
//   rst_n    in   asynchronous active-low reset; all flops clear to 0
//   i_async  in   asynchronous input level
//   o_sync   out  synchronized level (output of the last flop)

module pll_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - video PLL lock supervisor with staged downstream reset release
//
// Purpose: watches PLL LOCK, pulses PLL RST when lock never arrives, holds
//          downstream resets until lock is stable, then releases them one
//          stage at a time; any lock loss after release re-asserts them all.
// Build option: PLL_RESET_CTRL_EN - when defined, the PLL_RESET state and the
//          lock timeout exist and pll_rst_o is driven; when undefined,
//          pll_rst_o is tied 0 and WAIT_LOCK waits indefinitely.
// Ports:
//   clk             in   25 MHz reference clock (only clock)
//   rst_n           in   asynchronous active-low reset
//   pll_locked_i    in   PLL LOCK, asynchronous to clk
//   pll_rst_o       out  PLL RST, active high
//   rst_n_o         out  NUM_STAGES active-low downstream resets, bit 0 first
//   ready_o         out  all stages released and PLL locked
//   unlock_count_o  out  lock losses seen after release, saturating at 255
//   state_o         out  current FSM state (debug)

import pll_lock_supervisor_pkg::*;

module pll_lock_supervisor #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int NUM_STAGES          = 3,
  parameter int STAGE_GAP_CYCLES    = 64,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked_i,
  output logic                  pll_rst_o,
  output logic [NUM_STAGES-1:0] rst_n_o,
  output logic                  ready_o,
  output logic [7:0]            unlock_count_o,
  output logic [2:0]            state_o
);

  // A single counter serves every timed state; it is cleared on each
  // state change, so its width follows the largest terminal count.
  localparam int CNT_MAX = max2(max2(LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES),
                                max2(PLL_RST_CYCLES, STAGE_GAP_CYCLES));
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 1);
`ifdef PLL_RESET_CTRL_EN
  localparam logic [CNT_W-1:0] PRST_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam state_t           RESET_STATE = PLL_RESET;
`else
  localparam state_t           RESET_STATE = WAIT_LOCK;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [NUM_STAGES-1:0] r_rst_n;
  logic [NUM_STAGES-1:0] w_rst_n_nxt;
  logic [NUM_STAGES-1:0] w_rst_n_shift;
  logic                  r_ready;
  logic                  w_ready_nxt;
  logic [7:0]            r_unlock;
  logic [7:0]            w_unlock_nxt;
  logic                  w_lk;
`ifdef PLL_RESET_CTRL_EN
  logic                  r_pll_rst;
  logic                  w_pll_rst_nxt;
`endif

  pll_lock_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (pll_locked_i),
    .o_sync  (w_lk)
  );

  // Releasing the next stage is a shift of a 1 into the bottom of the
  // thermometer code, which keeps the order strictly bit 0 upward and
  // also covers NUM_STAGES == 1 without a zero-width slice.
  assign w_rst_n_shift = NUM_STAGES'({r_rst_n, 1'b1});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RESET_STATE;
      r_cnt     <= '0;
      r_rst_n   <= '0;
      r_ready   <= 1'b0;
      r_unlock  <= '0;
`ifdef PLL_RESET_CTRL_EN
      r_pll_rst <= 1'b1;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rst_n   <= w_rst_n_nxt;
      r_ready   <= w_ready_nxt;
      r_unlock  <= w_unlock_nxt;
`ifdef PLL_RESET_CTRL_EN
      r_pll_rst <= w_pll_rst_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rst_n_nxt   = r_rst_n;
    w_ready_nxt   = r_ready;
    w_unlock_nxt  = r_unlock;
`ifdef PLL_RESET_CTRL_EN
    w_pll_rst_nxt = r_pll_rst;
`endif

    case (r_state)
`ifdef PLL_RESET_CTRL_EN
      PLL_RESET: begin
        w_pll_rst_nxt = 1'b1;
        if (r_cnt == PRST_LAST) begin
          w_state_nxt   = WAIT_LOCK;
          w_pll_rst_nxt = 1'b0;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
`endif

      WAIT_LOCK: begin
        // Lock wins over the timeout when both happen on the same edge.
        if (w_lk) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
`ifdef PLL_RESET_CTRL_EN
        end else if (r_cnt == TMO_LAST) begin
          w_state_nxt   = PLL_RESET;
          w_pll_rst_nxt = 1'b1;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
`endif
        end
      end

      STABLE: begin
        if (!w_lk) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_cnt_nxt   = '0;
          w_rst_n_nxt = w_rst_n_shift;
          if (&w_rst_n_shift) begin
            w_state_nxt = RUN;
            w_ready_nxt = 1'b1;
          end else begin
            w_state_nxt = RELEASE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      RELEASE, RUN: begin
        if (!w_lk) begin
          // Re-lock is attempted without touching the PLL; if it never
          // comes back, the WAIT_LOCK timeout takes over.
          w_state_nxt  = WAIT_LOCK;
          w_cnt_nxt    = '0;
          w_rst_n_nxt  = '0;
          w_ready_nxt  = 1'b0;
          w_unlock_nxt = (r_unlock == 8'hFF) ? r_unlock : (r_unlock + 8'd1);
        end else if (r_state == RELEASE) begin
          if (r_cnt == GAP_LAST) begin
            w_cnt_nxt   = '0;
            w_rst_n_nxt = w_rst_n_shift;
            if (&w_rst_n_shift) begin
              w_state_nxt = RUN;
              w_ready_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end

      default: begin
        w_state_nxt = RESET_STATE;
        w_cnt_nxt   = '0;
        w_rst_n_nxt = '0;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

`ifdef PLL_RESET_CTRL_EN
  assign pll_rst_o = r_pll_rst;
`else
  assign pll_rst_o = 1'b0;
`endif
  assign rst_n_o        = r_rst_n;
  assign ready_o        = r_ready;
  assign unlock_count_o = r_unlock;
  assign state_o        = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - self-checking bench for pll_lock_supervisor

module tb_pll_lock_supervisor;

`ifdef PLL_RESET_CTRL_EN
  localparam bit CTRL = 1'b1;
  localparam int OFF  = 0;
`else
  localparam bit CTRL = 1'b0;
  localparam int OFF  = -2;
`endif
  localparam int SEL_PLL   = 0;
  localparam int SEL_RSTN  = 1;
  localparam int SEL_RDY   = 2;
  localparam int SEL_CNT   = 3;
  localparam int SEL_STATE = 4;
  localparam int SEL_LOCK  = 9;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst_n = 1'b0;
  logic       pll_locked_i = 1'b1;
  logic       pll_rst_o;
  logic [2:0] rst_n_o;
  logic       ready_o;
  logic [7:0] unlock_count_o;
  logic [2:0] state_o;

  int edge_cnt = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         e;
    int         sel;
    logic [7:0] v;
    string      tag;
  } ev_t;

  ev_t sb_q[$];

  pll_lock_supervisor #(
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .PLL_RST_CYCLES      (4),
    .NUM_STAGES          (3),
    .STAGE_GAP_CYCLES    (2),
    .SYNC_STAGES         (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pll_locked_i   (pll_locked_i),
    .pll_rst_o      (pll_rst_o),
    .rst_n_o        (rst_n_o),
    .ready_o        (ready_o),
    .unlock_count_o (unlock_count_o),
    .state_o        (state_o)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  function automatic logic [7:0] observe(input int sel);
    logic [7:0] r;
    r = '0;
    case (sel)
      SEL_PLL:   r = {7'd0, pll_rst_o};
      SEL_RSTN:  r = {5'd0, rst_n_o};
      SEL_RDY:   r = {7'd0, ready_o};
      SEL_CNT:   r = unlock_count_o;
      SEL_STATE: r = {5'd0, state_o};
      default:   r = 8'hEE;
    endcase
    return r;
  endfunction

  task automatic push(input int e, input int sel, input logic [7:0] v, input string tag);
    ev_t ev;
    ev.e = e; ev.sel = sel; ev.v = v; ev.tag = tag;
    sb_q.push_back(ev);
  endtask

  // Pops entries in order; each waits for its edge (sampled on the
  // following falling edge) and either drives the lock input or compares.
  task automatic drain();
    ev_t ev;
    int  guard;
    guard = 0;
    while (sb_q.size() > 0) begin
      ev = sb_q.pop_front();
      while (edge_cnt < ev.e && guard < 20000) begin
        @(negedge clk);
        guard++;
      end
      if (edge_cnt < ev.e) begin
        chk({ev.tag, "_timeout"}, 8'(edge_cnt), 8'(ev.e));
        sb_q.delete();
      end else if (ev.sel == SEL_LOCK) begin
        pll_locked_i = ev.v[0];
      end else begin
        chk(ev.tag, observe(ev.sel), ev.v);
      end
    end
  endtask

  task automatic apply_reset(input logic lock);
    rst_n = 1'b0;
    pll_locked_i = lock;
    clk_run = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_reset_values(input string pfx);
    push(0, SEL_PLL,   {7'd0, CTRL}, {pfx, "_pll"});
    push(0, SEL_RSTN,  8'd0,         {pfx, "_rstn"});
    push(0, SEL_RDY,   8'd0,         {pfx, "_rdy"});
    push(0, SEL_CNT,   8'd0,         {pfx, "_cnt"});
    push(0, SEL_STATE, CTRL ? 8'd0 : 8'd1, {pfx, "_state"});
  endtask

  initial begin
    int b;
    int k;

    // Lock held high from the start: pulse, stable window, staggered release.
    apply_reset(1'b1);
    push_reset_values("rst");
    if (CTRL) begin
      push(3, SEL_PLL,   8'd1, "pll_e3");
      push(4, SEL_PLL,   8'd0, "pll_e4");
      push(4, SEL_STATE, 8'd1, "wait_e4");
    end
    push(5 + OFF,  SEL_STATE, 8'd2, "stable_in");
    push(12 + OFF, SEL_RSTN,  8'd0, "rstn_e12");
    push(13 + OFF, SEL_RSTN,  8'd1, "rstn_e13");
    push(13 + OFF, SEL_STATE, 8'd3, "release_in");
    push(14 + OFF, SEL_RSTN,  8'd1, "rstn_e14");
    push(15 + OFF, SEL_RSTN,  8'd3, "rstn_e15");
    push(16 + OFF, SEL_RDY,   8'd0, "rdy_e16");
    push(17 + OFF, SEL_RSTN,  8'd7, "rstn_e17");
    push(17 + OFF, SEL_RDY,   8'd1, "rdy_e17");
    push(17 + OFF, SEL_STATE, 8'd4, "run_in");
    push(17 + OFF, SEL_PLL,   8'd0, "pll_run");
    drain();

    // One-cycle lock glitch while counting stable lock.
    apply_reset(1'b1);
    push(8 + OFF,  SEL_LOCK,  8'd0, "glitch_lo");
    push(9 + OFF,  SEL_LOCK,  8'd1, "glitch_hi");
    push(11 + OFF, SEL_STATE, 8'd1, "glitch_wait");
    push(12 + OFF, SEL_STATE, 8'd2, "glitch_stable");
    push(13 + OFF, SEL_RSTN,  8'd0, "glitch_rstn13");
    push(19 + OFF, SEL_RSTN,  8'd0, "glitch_rstn19");
    push(20 + OFF, SEL_RSTN,  8'd1, "glitch_rstn20");
    push(20 + OFF, SEL_CNT,   8'd0, "glitch_cnt");
    push(24 + OFF, SEL_RSTN,  8'd7, "glitch_rstn24");
    push(24 + OFF, SEL_RDY,   8'd1, "glitch_rdy");

    // Lock loss in RUN, then relock and a second staged release.
    push(30 + OFF, SEL_LOCK,  8'd0, "loss_lo");
    push(32 + OFF, SEL_RSTN,  8'd7, "loss_rstn32");
    push(33 + OFF, SEL_RSTN,  8'd0, "loss_rstn");
    push(33 + OFF, SEL_RDY,   8'd0, "loss_rdy");
    push(33 + OFF, SEL_CNT,   8'd1, "loss_cnt");
    push(33 + OFF, SEL_STATE, 8'd1, "loss_state");
    push(33 + OFF, SEL_PLL,   8'd0, "loss_nopll");
    push(35 + OFF, SEL_LOCK,  8'd1, "relock_hi");
    push(38 + OFF, SEL_STATE, 8'd2, "relock_stable");
    push(45 + OFF, SEL_RSTN,  8'd0, "relock_rstn45");
    push(46 + OFF, SEL_RSTN,  8'd1, "relock_rstn46");
    push(48 + OFF, SEL_RSTN,  8'd3, "relock_rstn48");
    push(50 + OFF, SEL_RSTN,  8'd7, "relock_rstn50");
    push(50 + OFF, SEL_RDY,   8'd1, "relock_rdy");

    // 300 further losses, one every 20 edges; the counter must stick at 255.
    b = 0;
    for (k = 0; k < 300; k++) begin
      b = 52 + OFF + 20 * k;
      push(b, SEL_LOCK, 8'd0, "sat_lo");
      if (k == 0) push(b + 3, SEL_RSTN, 8'd0, "sat_rstn0");
      if (k == 0 || k == 252 || k == 253 || k == 299)
        push(b + 3, SEL_CNT, (k + 2 > 255) ? 8'd255 : 8'(k + 2),
             $sformatf("sat_cnt_k%0d", k));
      push(b + 3, SEL_LOCK, 8'd1, "sat_hi");
    end
    push(b + 16, SEL_RSTN,  8'd3, "pre_async_rstn");
    push(b + 16, SEL_STATE, 8'd3, "pre_async_state");
    drain();

    // Asynchronous reset in the middle of RELEASE with the clock stopped.
    clk_run = 1'b0;
    #3;
    rst_n = 1'b0;
    #4;
    push_reset_values("async");
    drain();

    // Lock never arrives.
    apply_reset(1'b0);
    if (CTRL) begin
      push(3,  SEL_PLL, 8'd1, "nolock_pll3");
      push(4,  SEL_PLL, 8'd0, "nolock_pll4");
      push(35, SEL_PLL, 8'd0, "nolock_pll35");
      push(36, SEL_PLL, 8'd1, "nolock_pll36");
      push(39, SEL_PLL, 8'd1, "nolock_pll39");
      push(40, SEL_PLL, 8'd0, "nolock_pll40");
      push(71, SEL_PLL, 8'd0, "nolock_pll71");
      push(72, SEL_PLL, 8'd1, "nolock_pll72");
      push(75, SEL_PLL, 8'd1, "nolock_pll75");
      push(76, SEL_PLL, 8'd0, "nolock_pll76");
      push(76, SEL_RSTN, 8'd0, "nolock_rstn");
    end else begin
      push(1,    SEL_PLL,   8'd0, "nolock_pll1");
      push(500,  SEL_PLL,   8'd0, "nolock_pll500");
      push(1000, SEL_PLL,   8'd0, "nolock_pll1000");
      push(1000, SEL_STATE, 8'd1, "nolock_state");
      push(1000, SEL_RSTN,  8'd0, "nolock_rstn");
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
